// File: rtl/parity_frame_checker_pkg.sv
// Shared types and helpers for the serial parity frame checker.
// Holds the receive FSM state encoding and the expected-parity function
// that the generator side also uses, so both ends agree on one definition.
package parity_frame_pkg;

  // Widest data word the shared parity helper accepts. Narrower words are
  // zero-extended by the caller; zero bits do not change an XOR reduction.
  localparam int MAX_DATA_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // waiting for a frame_start
    DATA = 2'd1,  // collecting data bits 1..DATA_W-1
    PAR  = 2'd2   // next qualified bit is the parity bit
  } state_e;

  // Expected parity bit for a data word.
  // odd = 0 : even parity, bit = ^data
  // odd = 1 : odd parity,  bit = ~^data
  function automatic logic exp_parity(input logic [MAX_DATA_W-1:0] data,
                                      input logic                  odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/parity_frame_checker_if.sv
// Bundle of the serial input, the checked-word output handshake and the
// link-status strobes of the parity frame checker.
// slave modport: the checker's view. master modport: the driver/consumer view.
interface parity_frame_checker_if #(
  parameter int DATA_W    = 8,
  parameter int ERR_CNT_W = 8
) ();

  // serial side
  logic                 bit_valid;
  logic                 bit_in;
  logic                 frame_start;

  // checked-word side
  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_W-1:0]    out_data;
  logic                 out_par_err;
  logic                 out_all_ones;
  logic                 out_all_zeros;

  // link status
  logic [ERR_CNT_W-1:0] err_count;
  logic                 overrun;
  logic                 abort;

  modport slave (
    input  bit_valid, bit_in, frame_start, out_ready,
    output out_valid, out_data, out_par_err, out_all_ones, out_all_zeros,
           err_count, overrun, abort
  );

  modport master (
    output bit_valid, bit_in, frame_start, out_ready,
    input  out_valid, out_data, out_par_err, out_all_ones, out_all_zeros,
           err_count, overrun, abort
  );

endinterface

// File: rtl/parity_frame_checker.sv
// Purpose: deserialize LSB-first DATA_W-bit frames plus parity bit, check parity.
// Latency: checked word is visible the cycle after the parity bit is sampled.
// Backpressure: one-entry output register; a frame completing while it is full and not popped is dropped with an overrun pulse.
//
// Ports: clk, rst_n (async active-low) and pf (slave modport) carrying
// bit_valid/bit_in/frame_start in, out_valid/out_ready/out_data/out_par_err/
// out_all_ones/out_all_zeros out, plus err_count, overrun and abort status.
module parity_frame_checker
  import parity_frame_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter bit ODD_PARITY = 1'b0,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  parity_frame_checker_if.slave pf
);

  localparam int                   IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(DATA_W - 1);
  localparam logic [ERR_CNT_W-1:0] CNT_MAX  = '1;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_e                 state_q,       state_d;
  logic [IDX_W-1:0]       idx_q,         idx_d;
  logic [DATA_W-1:0]      shift_q,       shift_d;
  logic                   out_valid_q,   out_valid_d;
  logic [DATA_W-1:0]      out_data_q,    out_data_d;
  logic                   out_par_err_q, out_par_err_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q,     err_cnt_d;
  logic                   overrun_q,     overrun_d;
  logic                   abort_q,       abort_d;

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  logic pop;       // consumer takes the held word this cycle
  logic complete;  // parity bit sampled this cycle
  logic par_err;   // parity mismatch for the frame completing this cycle

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    shift_d       = shift_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_par_err_d = out_par_err_q;
    err_cnt_d     = err_cnt_q;
    overrun_d     = 1'b0;
    abort_d       = 1'b0;
    complete      = 1'b0;

    pop     = out_valid_q && pf.out_ready;
    par_err = (pf.bit_in != exp_parity(MAX_DATA_W'(shift_q), ODD_PARITY));

    if (pop) begin
      out_valid_d = 1'b0;
    end

    if (pf.bit_valid) begin
      if (pf.frame_start) begin
        // A new frame always wins, even over a pending parity bit. Only a
        // frame that was actually in progress counts as aborted.
        abort_d = (state_q != IDLE);
        shift_d = {{(DATA_W-1){1'b0}}, pf.bit_in};
        idx_d   = IDX_W'(1);
        state_d = DATA;
      end else begin
        unique case (state_q)
          IDLE: begin
            // stray bit outside a frame: ignored
          end
          DATA: begin
            shift_d[idx_q] = pf.bit_in;
            if (idx_q == LAST_IDX) begin
              idx_d   = '0;
              state_d = PAR;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
          PAR: begin
            complete = 1'b1;
            idx_d    = '0;
            state_d  = IDLE;
          end
          default: begin
            idx_d   = '0;
            state_d = IDLE;
          end
        endcase
      end
    end

    if (complete) begin
      // The register is free if empty or being popped this same cycle.
      if (!out_valid_q || pf.out_ready) begin
        out_valid_d   = 1'b1;
        out_data_d    = shift_q;
        out_par_err_d = par_err;
        if (par_err && (err_cnt_q != CNT_MAX)) begin
          err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
      end else begin
        // Held word is kept; the new frame and its error status are lost.
        overrun_d = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      shift_q       <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_par_err_q <= 1'b0;
      err_cnt_q     <= '0;
      overrun_q     <= 1'b0;
      abort_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      shift_q       <= shift_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_par_err_q <= out_par_err_d;
      err_cnt_q     <= err_cnt_d;
      overrun_q     <= overrun_d;
      abort_q       <= abort_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign pf.out_valid     = out_valid_q;
  assign pf.out_data      = out_data_q;
  assign pf.out_par_err   = out_par_err_q;
  assign pf.out_all_ones  = &out_data_q;
  assign pf.out_all_zeros = ~|out_data_q;
  assign pf.err_count     = err_cnt_q;
  assign pf.overrun       = overrun_q;
  assign pf.abort         = abort_q;

endmodule

// File: tb/tb_parity_frame_checker.sv
// Directed bench for parity_frame_checker: three instances share one serial
// stimulus (even/8-bit counter, odd parity, 2-bit counter); each test checks
// the instance whose configuration it exercises.
module tb_parity_frame_checker;

  logic clk;
  logic rst_n;
  logic bit_valid;
  logic bit_in;
  logic frame_start;
  logic out_ready;

  int total;
  int bad;

  parity_frame_checker_if #(.DATA_W(8), .ERR_CNT_W(8)) if_main ();
  parity_frame_checker_if #(.DATA_W(8), .ERR_CNT_W(8)) if_odd  ();
  parity_frame_checker_if #(.DATA_W(8), .ERR_CNT_W(2)) if_sat  ();

  assign if_main.bit_valid   = bit_valid;
  assign if_main.bit_in      = bit_in;
  assign if_main.frame_start = frame_start;
  assign if_main.out_ready   = out_ready;
  assign if_odd.bit_valid    = bit_valid;
  assign if_odd.bit_in       = bit_in;
  assign if_odd.frame_start  = frame_start;
  assign if_odd.out_ready    = out_ready;
  assign if_sat.bit_valid    = bit_valid;
  assign if_sat.bit_in       = bit_in;
  assign if_sat.frame_start  = frame_start;
  assign if_sat.out_ready    = out_ready;

  parity_frame_checker #(.DATA_W(8), .ODD_PARITY(1'b0), .ERR_CNT_W(8)) u_main (
    .clk(clk), .rst_n(rst_n), .pf(if_main));
  parity_frame_checker #(.DATA_W(8), .ODD_PARITY(1'b1), .ERR_CNT_W(8)) u_odd (
    .clk(clk), .rst_n(rst_n), .pf(if_odd));
  parity_frame_checker #(.DATA_W(8), .ODD_PARITY(1'b0), .ERR_CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .pf(if_sat));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock with the given serial inputs; returns 1 time unit after the edge.
  task automatic step(input logic v, input logic b, input logic fs);
    bit_valid = v; bit_in = b; frame_start = fs;
    @(posedge clk); #1;
    bit_valid = 1'b0; bit_in = 1'b0; frame_start = 1'b0;
  endtask

  task automatic send_data(input logic [7:0] d, input int nbits);
    for (int i = 0; i < nbits; i++) step(1'b1, d[i], i == 0);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p);
    send_data(d, 8);
    step(1'b1, p, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; #1;
    total++; if (if_main.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", if_main.out_valid); end
    total++; if (if_main.out_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", if_main.out_data); end
    total++; if (if_main.out_all_zeros !== 1'b1 || if_main.out_all_ones !== 1'b0 || if_main.out_par_err !== 1'b0) begin
      bad++; $display("FAIL reset_flags zeros=%b ones=%b perr=%b exp 1/0/0", if_main.out_all_zeros, if_main.out_all_ones, if_main.out_par_err); end
    total++; if (if_main.err_count !== 8'd0 || if_main.overrun !== 1'b0 || if_main.abort !== 1'b0) begin
      bad++; $display("FAIL reset_status cnt=%0d ovr=%b abt=%b exp 0/0/0", if_main.err_count, if_main.overrun, if_main.abort); end
    step(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    do_reset();
    out_ready = 1'b1;
    send_data(8'hA5, 8);
    total++; if (if_main.out_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%b exp=0", if_main.out_valid); end
    step(1'b1, 1'b0, 1'b0);
    total++; if (if_main.out_valid !== 1'b1 || if_main.out_data !== 8'hA5) begin
      bad++; $display("FAIL basic_word valid=%b data=%h exp 1/a5", if_main.out_valid, if_main.out_data); end
    total++; if (if_main.out_par_err !== 1'b0 || if_main.err_count !== 8'd0) begin
      bad++; $display("FAIL basic_err perr=%b cnt=%0d exp 0/0", if_main.out_par_err, if_main.err_count); end
    total++; if (if_main.out_all_ones !== 1'b0 || if_main.out_all_zeros !== 1'b0) begin
      bad++; $display("FAIL basic_flags ones=%b zeros=%b exp 0/0", if_main.out_all_ones, if_main.out_all_zeros); end
    step(1'b0, 1'b0, 1'b0);
    total++; if (if_main.out_valid !== 1'b0) begin bad++; $display("FAIL basic_pop valid=%b exp=0", if_main.out_valid); end
  endtask

  task automatic test_parity_err();
    do_reset();
    out_ready = 1'b1;
    send_frame(8'h01, 1'b0);
    total++; if (if_main.out_par_err !== 1'b1 || if_main.err_count !== 8'd1 || if_main.out_data !== 8'h01) begin
      bad++; $display("FAIL perr_01 perr=%b cnt=%0d data=%h exp 1/1/01", if_main.out_par_err, if_main.err_count, if_main.out_data); end
    send_frame(8'hFF, 1'b0);
    total++; if (if_main.out_par_err !== 1'b0 || if_main.out_all_ones !== 1'b1 || if_main.err_count !== 8'd1) begin
      bad++; $display("FAIL perr_ff perr=%b ones=%b cnt=%0d exp 0/1/1", if_main.out_par_err, if_main.out_all_ones, if_main.err_count); end
  endtask

  task automatic test_odd();
    do_reset();
    out_ready = 1'b1;
    send_frame(8'hFF, 1'b1);
    total++; if (if_odd.out_valid !== 1'b1 || if_odd.out_par_err !== 1'b0 || if_odd.err_count !== 8'd0) begin
      bad++; $display("FAIL odd_ff valid=%b perr=%b cnt=%0d exp 1/0/0", if_odd.out_valid, if_odd.out_par_err, if_odd.err_count); end
    total++; if (if_main.out_par_err !== 1'b1 || if_main.err_count !== 8'd1) begin
      bad++; $display("FAIL odd_vs_even perr=%b cnt=%0d exp 1/1", if_main.out_par_err, if_main.err_count); end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    send_frame(8'h3C, 1'b0);
    total++; if (if_main.out_valid !== 1'b1 || if_main.out_data !== 8'h3C) begin
      bad++; $display("FAIL bp_load valid=%b data=%h exp 1/3c", if_main.out_valid, if_main.out_data); end
    // second frame carries a parity error and must be dropped without counting
    send_data(8'h0F, 8);
    total++; if (if_main.out_data !== 8'h3C) begin bad++; $display("FAIL bp_stable data=%h exp=3c", if_main.out_data); end
    step(1'b1, 1'b1, 1'b0);
    total++; if (if_main.overrun !== 1'b1 || if_main.out_data !== 8'h3C || if_main.out_valid !== 1'b1) begin
      bad++; $display("FAIL bp_overrun ovr=%b data=%h valid=%b exp 1/3c/1", if_main.overrun, if_main.out_data, if_main.out_valid); end
    total++; if (if_main.err_count !== 8'd0 || if_main.out_par_err !== 1'b0) begin
      bad++; $display("FAIL bp_drop_cnt cnt=%0d perr=%b exp 0/0", if_main.err_count, if_main.out_par_err); end
    step(1'b0, 1'b0, 1'b0);
    total++; if (if_main.overrun !== 1'b0) begin bad++; $display("FAIL bp_ovr_pulse ovr=%b exp=0", if_main.overrun); end
    send_data(8'h81, 8);
    out_ready = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    total++; if (if_main.out_valid !== 1'b1 || if_main.out_data !== 8'h81 || if_main.overrun !== 1'b0) begin
      bad++; $display("FAIL bp_pop_push valid=%b data=%h ovr=%b exp 1/81/0", if_main.out_valid, if_main.out_data, if_main.overrun); end
    step(1'b0, 1'b0, 1'b0);
    total++; if (if_main.out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain valid=%b exp=0", if_main.out_valid); end
  endtask

  task automatic test_abort();
    do_reset();
    out_ready = 1'b1;
    step(1'b1, 1'b1, 1'b1);
    total++; if (if_main.abort !== 1'b0) begin bad++; $display("FAIL abort_idle abt=%b exp=0", if_main.abort); end
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    send_data(8'h5A, 1);
    total++; if (if_main.abort !== 1'b1) begin bad++; $display("FAIL abort_pulse abt=%b exp=1", if_main.abort); end
    for (int i = 1; i < 8; i++) step(1'b1, 1'(8'h5A >> i), 1'b0);
    total++; if (if_main.abort !== 1'b0 || if_main.out_valid !== 1'b0) begin
      bad++; $display("FAIL abort_after abt=%b valid=%b exp 0/0", if_main.abort, if_main.out_valid); end
    step(1'b1, 1'b0, 1'b0);
    total++; if (if_main.out_valid !== 1'b1 || if_main.out_data !== 8'h5A || if_main.out_par_err !== 1'b0) begin
      bad++; $display("FAIL abort_new_frame valid=%b data=%h perr=%b exp 1/5a/0", if_main.out_valid, if_main.out_data, if_main.out_par_err); end
  endtask

  task automatic test_back_to_back_saturate();
    logic [1:0] exp_cnt [5];
    exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3; exp_cnt[3] = 2'd3; exp_cnt[4] = 2'd3;
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      send_frame(8'h01, 1'b0);
      total++; if (if_sat.err_count !== exp_cnt[k] || if_sat.out_par_err !== 1'b1) begin
        bad++; $display("FAIL sat_cnt_%0d cnt=%0d perr=%b exp %0d/1", k, if_sat.err_count, if_sat.out_par_err, exp_cnt[k]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    out_ready = 1'b1;
    send_frame(8'h33, 1'b1);
    total++; if (if_main.out_valid !== 1'b1 || if_main.err_count !== 8'd1) begin
      bad++; $display("FAIL rmf_pre valid=%b cnt=%0d exp 1/1", if_main.out_valid, if_main.err_count); end
    send_data(8'h6B, 5);
    rst_n = 1'b0; #1;
    total++; if (if_main.out_valid !== 1'b0 || if_main.out_data !== 8'h00 || if_main.out_all_zeros !== 1'b1) begin
      bad++; $display("FAIL rmf_async valid=%b data=%h zeros=%b exp 0/00/1", if_main.out_valid, if_main.out_data, if_main.out_all_zeros); end
    total++; if (if_main.err_count !== 8'd0 || if_main.abort !== 1'b0 || if_main.overrun !== 1'b0) begin
      bad++; $display("FAIL rmf_status cnt=%0d abt=%b ovr=%b exp 0/0/0", if_main.err_count, if_main.abort, if_main.overrun); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    // nine qualified bits without frame_start must not form a frame
    for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 1'b0);
    total++; if (if_main.out_valid !== 1'b0) begin bad++; $display("FAIL rmf_ignored valid=%b exp=0", if_main.out_valid); end
    send_frame(8'hC3, 1'b0);
    total++; if (if_main.out_valid !== 1'b1 || if_main.out_data !== 8'hC3 || if_main.out_par_err !== 1'b0) begin
      bad++; $display("FAIL rmf_next valid=%b data=%h perr=%b exp 1/c3/0", if_main.out_valid, if_main.out_data, if_main.out_par_err); end
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; frame_start = 1'b0; out_ready = 1'b0;
    test_reset();
    test_basic();
    test_parity_err();
    test_odd();
    test_backpressure();
    test_abort();
    test_back_to_back_saturate();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/parity_frame_checker.md
Name: parity_frame_checker

Overview:
- Receive-side counterpart to our reduction-based parity generator.
- Deserializes a bit-serial frame, LSB first: DATA_W data bits, then one parity bit.
- Recomputes parity by XOR reduction and flags mismatches.
- Presents each checked word through a one-entry valid/ready output register, with a saturating error counter and overrun/abort strobes for the link status block.

Parameters:
- DATA_W, 8, data bits per frame (>=2)
- ODD_PARITY, 0, 0 = even parity (parity bit = ^data), 1 = odd parity (parity bit = ~^data)
- ERR_CNT_W, 8, width of saturating parity-error counter

Ports:
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- bit_valid  input  1  bit_in/frame_start qualified this cycle
- bit_in  input  1  serial bit
- frame_start  input  1  with bit_valid: bit_in is data bit 0 of a new frame
- out_valid  output  1  output register holds a checked word
- out_ready  input  1  consumer accepts word when out_valid && out_ready
- out_data  output  DATA_W  received data word
- out_par_err  output  1  parity mismatch for out_data
- out_all_ones  output  1  &out_data
- out_all_zeros  output  1  ~|out_data
- err_count  output  ERR_CNT_W  saturating count of parity-error frames loaded
- overrun  output  1  one-cycle pulse: completed frame dropped, output register full
- abort  output  1  one-cycle pulse: partial frame discarded by frame_start

Behaviour:
- Reset values (async, immediate on rst_n low): state IDLE, bit index 0, shift register 0, out_valid 0, out_data 0, out_par_err 0, err_count 0, overrun 0, abort 0. out_all_ones and out_all_zeros are derived from out_data, so out_all_zeros=1 in reset.
- Cycles with bit_valid=0 change no state.
- FSM states:
  - IDLE: bit_valid && frame_start → store bit_in as data bit 0, idx=1, go DATA. bit_valid without frame_start is ignored.
  - DATA: each bit_valid stores bit_in at position idx and increments idx. After bit DATA_W-1 is stored, go PAR.
  - PAR: next bit_valid is the parity bit and completes the frame; go IDLE.
- frame_start in DATA or PAR:
  - Discard the partial frame and pulse abort for one cycle.
  - Treat bit_in as data bit 0 of the new frame: idx=1, state DATA.
  - frame_start in IDLE never pulses abort.
- Check on completion:
  - exp = (^data) ^ ODD_PARITY.
  - err = (parity_bit != exp).
- Latency: out_valid, out_data and out_par_err update on the same edge that samples the parity bit, so they are visible the cycle after the parity bit is presented.
- Output register loads on completion when it is free, i.e. !out_valid, or out_valid && out_ready in that same cycle (pop and push together; out_valid stays 1).
- Completion while out_valid && !out_ready:
  - Frame dropped; out_data and out_par_err unchanged.
  - overrun pulses for one cycle.
  - err_count is not incremented, even if the dropped frame had a parity error.
- Handshake:
  - out_valid falls after an accept when no load happens that cycle.
  - out_data is stable while out_valid && !out_ready.
- err_count:
  - +1 on each load with err=1.
  - Saturates at all-ones, no wrap.
  - Cleared only by reset.
- Reset mid-frame: partial frame and output register cleared; no pulses.

Decomposition:
- Package parity_frame_pkg holds:
  - state enum {IDLE, DATA, PAR}
  - function exp_parity(data, odd) returning ^data ^ odd, shared with the generator side
- No sub-module; shift register, FSM and output register are all in one module.

Test Plan:
- DATA_W=8, even parity. Frame 0xA5 sent LSB first (bits 1,0,1,0,0,1,0,1), parity 0, out_ready=1 → out_valid 1 cycle after parity bit, out_data=0xA5, out_par_err=0, err_count=0, out_all_ones=0, out_all_zeros=0.
- Frame 0x01 with parity 0 → out_par_err=1, err_count=1. Frame 0xFF with parity 0 → out_par_err=0, out_all_ones=1. With ODD_PARITY=1, 0xFF with parity 1 → no error.
- out_ready=0: frame 0x3C loads. Second frame 0x0F completes → overrun pulse, out_data stays 0x3C. Raise out_ready in the cycle the third frame 0x81 completes → pop 0x3C and load 0x81 together, out_valid stays 1.
- frame_start asserted after 4 data bits → abort pulse. The new 9-bit frame 0x5A/parity 0 completes normally.
- ERR_CNT_W=2: five parity-error frames → err_count 1,2,3,3,3.
- Assert rst_n low after 5 data bits → all outputs at reset values immediately. A subsequent bit without frame_start is ignored; the next full frame is checked correctly.
